// File: rtl/sub_pkg.sv
// Shared definitions for the subtractor datapath: operand widths and the
// operand loader state encoding.
package sub_pkg;

   localparam int OPERAND_W = 8;
   localparam int PAIR_W    = 2 * OPERAND_W;

   // Plain-vector state type so older blocks can compare against raw bits
   typedef logic [0:0] loader_state_t;
   localparam loader_state_t WAIT_A = 1'b0;
   localparam loader_state_t HAVE_A = 1'b1;

endpackage

// File: rtl/pair_out_slot.sv
// Single-entry valid/ready output register with a load port and drain logic.
// A load in the same cycle as a drain replaces the word without a bubble.
module pair_out_slot #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         can_load
);

   assign can_load = !out_valid || out_ready;

   // Load wins over drain so a simultaneous drain+load keeps out_valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sub_operand_loader.sv
// Packs a byte stream into {A, B} operand words for the subtractor stage.
// Optional SUB_OPERAND_SWAP_EN adds a swap input that packs {B, A} instead.
module sub_operand_loader
   import sub_pkg::*;
#(
   parameter int DATA_W = OPERAND_W,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
`ifdef SUB_OPERAND_SWAP_EN
   input  logic                swap,
`endif
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]    pair_count,
   output logic                busy
);

   loader_state_t       state;
   logic [DATA_W-1:0]   a_reg;
   logic                slot_can_load;
   logic                in_xfer;
   logic                slot_load;
   logic [2*DATA_W-1:0] load_word;

   // B can only be taken when the output slot has room this cycle
   always_comb begin
      in_ready = 1'b0;
      if (!clr) begin
         if (state == WAIT_A) in_ready = 1'b1;
         else                 in_ready = slot_can_load;
      end
   end

   assign in_xfer   = in_valid && in_ready;
   assign slot_load = in_xfer && (state == HAVE_A);

`ifdef SUB_OPERAND_SWAP_EN
   assign load_word = swap ? {in_data, a_reg} : {a_reg, in_data};
`else
   assign load_word = {a_reg, in_data};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_A;
         a_reg <= '0;
      end else if (clr) begin
         state <= WAIT_A;
      end else if (in_xfer) begin
         if (state == WAIT_A) begin
            a_reg <= in_data;
            state <= HAVE_A;
         end else begin
            state <= WAIT_A;
         end
      end
   end

   pair_out_slot #(
      .W (2 * DATA_W)
   ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load),
      .load_data (load_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .can_load  (slot_can_load)
   );

   // Counts delivered pairs and wraps freely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       pair_count <= '0;
      else if (out_valid && out_ready)  pair_count <= pair_count + CNT_W'(1);
   end

   assign busy = (state == HAVE_A) || out_valid;

endmodule

// File: tb/tb_sub_operand_loader.sv
// Directed self-checking bench for sub_operand_loader (CNT_W=2 to exercise wrap).
// Define SUB_OPERAND_SWAP_EN for both RTL and bench to cover the swap path.
module tb_sub_operand_loader;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  pair_count;
   logic        busy;
`ifdef SUB_OPERAND_SWAP_EN
   logic        swap;
`endif

   int assertCount = 0;
   int failCount   = 0;

   sub_operand_loader #(
      .DATA_W (8),
      .CNT_W  (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
`ifdef SUB_OPERAND_SWAP_EN
      .swap       (swap),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .pair_count (pair_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d,
                                input logic rdy, input logic c);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      clr       = c;
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic expOv,
                              input logic [15:0] expOd, input logic [1:0] expPc,
                              input logic expIr, input logic expBusy);
      assertCount++;
      assert (out_valid === expOv) else begin
         failCount++;
         $error("[TB] FAIL %s out_valid got %b want %b", tag, out_valid, expOv);
      end
      assertCount++;
      assert (out_data === expOd) else begin
         failCount++;
         $error("[TB] FAIL %s out_data got %h want %h", tag, out_data, expOd);
      end
      assertCount++;
      assert (pair_count === expPc) else begin
         failCount++;
         $error("[TB] FAIL %s pair_count got %0d want %0d", tag, pair_count, expPc);
      end
      assertCount++;
      assert (in_ready === expIr) else begin
         failCount++;
         $error("[TB] FAIL %s in_ready got %b want %b", tag, in_ready, expIr);
      end
      assertCount++;
      assert (busy === expBusy) else begin
         failCount++;
         $error("[TB] FAIL %s busy got %b want %b", tag, busy, expBusy);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
`ifdef SUB_OPERAND_SWAP_EN
      swap      = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();

      applyStimulus(0, 8'h00, 0, 0);
      checkOutput("reset", 0, 16'h0000, 0, 1, 0);

      // Basic pair 0x2C / 0x0F
      applyStimulus(1, 8'h2C, 1, 0);
      checkOutput("basic_a", 0, 16'h0000, 0, 1, 0);
      tick();
      applyStimulus(1, 8'h0F, 1, 0);
      checkOutput("basic_b", 0, 16'h0000, 0, 1, 1);
      tick();
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("basic_out", 1, 16'h2C0F, 0, 1, 1);
      tick();
      checkOutput("basic_drained", 0, 16'h2C0F, 1, 1, 0);

      // Backpressure: 0x50/0x10 held, A=0x33 overlaps, B=0x44 stalls
      applyStimulus(1, 8'h50, 0, 0);
      tick();
      applyStimulus(1, 8'h10, 0, 0);
      checkOutput("bp_b1", 0, 16'h2C0F, 1, 1, 1);
      tick();
      applyStimulus(1, 8'h33, 0, 0);
      checkOutput("bp_a2", 1, 16'h5010, 1, 1, 1);
      tick();
      applyStimulus(1, 8'h44, 0, 0);
      checkOutput("bp_stall1", 1, 16'h5010, 1, 0, 1);
      tick();
      checkOutput("bp_stall2", 1, 16'h5010, 1, 0, 1);
      applyStimulus(1, 8'h44, 1, 0);
      checkOutput("bp_release", 1, 16'h5010, 1, 1, 1);
      tick();
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("bp_nobubble", 1, 16'h3344, 2, 1, 1);
      tick();
      checkOutput("bp_drained", 0, 16'h3344, 3, 1, 0);

      // clr in HAVE_A discards A=0x7F and blocks byte 0x01
      applyStimulus(1, 8'h7F, 1, 0);
      tick();
      applyStimulus(1, 8'h01, 1, 1);
      checkOutput("clr_pulse", 0, 16'h3344, 3, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("clr_wait_a", 0, 16'h3344, 3, 1, 0);
      applyStimulus(1, 8'h40, 1, 0);
      tick();
      applyStimulus(1, 8'h20, 1, 0);
      tick();
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("clr_after", 1, 16'h4020, 3, 1, 1);
      tick();
      checkOutput("clr_wrap", 0, 16'h4020, 0, 1, 0);

      // clr in WAIT_A only blocks the byte
      applyStimulus(1, 8'h55, 1, 1);
      checkOutput("clr_idle", 0, 16'h4020, 0, 0, 0);
      tick();
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("clr_idle_after", 0, 16'h4020, 0, 1, 0);

      // Reset mid-operation with a pair pending and a half-loaded A
      applyStimulus(1, 8'h11, 1, 0);
      tick();
      applyStimulus(1, 8'h22, 1, 0);
      tick();
      applyStimulus(1, 8'hAA, 1, 0);
      tick();
      applyStimulus(1, 8'hBB, 0, 0);
      tick();
      applyStimulus(1, 8'hCC, 0, 0);
      tick();
      applyStimulus(0, 8'h00, 0, 0);
      checkOutput("pre_reset", 1, 16'hAABB, 1, 0, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 0, 16'h0000, 0, 1, 0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1, 8'h09, 1, 0);
      tick();
      applyStimulus(1, 8'h03, 1, 0);
      tick();
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("post_reset", 1, 16'h0903, 0, 1, 1);
      tick();
      checkOutput("wrap_1", 0, 16'h0903, 1, 1, 0);

      // Counter wrap: four more pairs give 2, 3, 0, 1
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 8'(i + 1), 1, 0);
         tick();
         applyStimulus(1, 8'(8'h80 + i), 1, 0);
         tick();
         applyStimulus(0, 8'h00, 1, 0);
         checkOutput("wrap_out", 1, {8'(i + 1), 8'(8'h80 + i)}, 2'(1 + i), 1, 1);
         tick();
         checkOutput("wrap_cnt", 0, {8'(i + 1), 8'(8'h80 + i)}, 2'(2 + i), 1, 0);
      end

`ifdef SUB_OPERAND_SWAP_EN
      // swap sampled only on the B cycle
      swap = 1'b0;
      applyStimulus(1, 8'h05, 1, 0);
      tick();
      swap = 1'b1;
      applyStimulus(1, 8'h12, 1, 0);
      tick();
      swap = 1'b0;
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("swap_on", 1, 16'h1205, 1, 1, 1);
      tick();
      swap = 1'b1;
      applyStimulus(1, 8'h05, 1, 0);
      tick();
      swap = 1'b0;
      applyStimulus(1, 8'h12, 1, 0);
      tick();
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("swap_off", 1, 16'h0512, 2, 1, 1);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/sub_operand_loader.md
Name: sub_operand_loader

Overview:
- Upstream feeder for the 8-bit subtractor stage.
- Accepts a byte stream over valid/ready. The first byte of each pair is the minuend A; the second is the subtrahend B.
- Packs each pair into one 16-bit word {A, B}, with A in [15:8] and B in [7:0], the exact operand layout the subtractor consumes.
- Holds the packed word in a registered output slot with valid/ready handshake, and counts delivered pairs.

Parameters:
- DATA_W, 8, operand width; output word is 2*DATA_W. The subtractor requires 8.
- CNT_W, 16, width of the delivered-pair counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush of a half-loaded pair.
- in_valid  input  1  byte available.
- in_ready  output  1  loader accepts the byte this cycle.
- in_data  input  DATA_W  operand byte.
- out_valid  output  1  packed pair available.
- out_ready  input  1  downstream consumes the pair this cycle.
- out_data  output  2*DATA_W  packed {A, B}.
- pair_count  output  CNT_W  number of pairs delivered on the output handshake.
- busy  output  1  high when state is HAVE_A or out_valid is high.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=WAIT_A, a_reg=0, out_valid=0, out_data=0, pair_count=0. Hence busy=0 and in_ready=1.
- Input handshake: a transfer occurs when in_valid && in_ready. Output handshake: a transfer occurs when out_valid && out_ready.
- FSM, two states:
  - WAIT_A: in_ready = !clr. On transfer, a_reg <= in_data and go to HAVE_A.
  - HAVE_A: in_ready = !clr && (!out_valid || out_ready). On transfer, out_data <= {a_reg, in_data}, out_valid <= 1, go to WAIT_A.
- Output slot:
  - out_valid, once set, stays high and out_data stays stable until the output handshake.
  - On an output handshake with no new B transfer in the same cycle, out_valid <= 0 and out_data holds its last value.
  - Output handshake and B transfer in the same cycle: the new word is loaded and out_valid stays 1. There is no bubble.
- Latency: out_valid rises the cycle after B is accepted.
- Throughput: one pair per 2 input cycles. A may be accepted while the output slot is still full, which overlaps the next load with the drain.
- pair_count increments by 1 on each output handshake and wraps modulo 2^CNT_W with no saturation.
- clr:
  - clr=1 in HAVE_A returns the FSM to WAIT_A, discarding a_reg.
  - clr forces in_ready=0, so a byte presented in that cycle is not accepted. clr takes priority over in_valid.
  - clr does not touch out_valid, out_data or pair_count.
  - clr in WAIT_A has no effect beyond in_ready=0.
- Backpressure: while in HAVE_A with out_valid=1 and out_ready=0, in_ready=0 and the B byte waits on the input.
- Reset mid-operation: asynchronous return to the reset values. A partial A and any undelivered pair are lost. pair_count is cleared.
- in_ready is combinational from state, clr, out_valid and out_ready. All other outputs are registered.

Optional Feature:
- Macro: SUB_OPERAND_SWAP_EN.
- With the macro defined:
  - Adds port swap (input, 1).
  - swap is sampled in the cycle B is accepted; when it is 1, out_data <= {B, A}, reversing subtraction order.
  - swap is ignored in all other cycles.
- Without the macro: the port is absent and the packing is always {A, B}.

Decomposition:
- Shared package sub_pkg holds:
  - the state typedef loader_state_t {WAIT_A, HAVE_A};
  - localparam OPERAND_W=8 and PAIR_W=2*OPERAND_W, shared with the subtractor wrapper.
- One natural sub-module: pair_out_slot. It is the single-entry valid/ready output register with a load port and drain logic, reusable for the subtractor's result register.
- The FSM and counter stay in the top module.

Test Plan:
- Basic pair: bytes 0x2C, then 0x0F, with out_ready=1 → out_data=0x2C0F with out_valid for 1 cycle, pair_count=1. Subtractor output 0x1D.
- Backpressure: hold out_ready=0, send 0x50/0x10, then 0x33 → 0x33 accepted (A of the second pair). The next byte sees in_ready=0 and out_data stays 0x5010. Raising out_ready → 0x5010 drains, next B accepted that cycle, out_valid stays 1.
- clr: send A=0x7F, then pulse clr together with in_valid and byte 0x01 → 0x01 not accepted, FSM in WAIT_A. Subsequent 0x40/0x20 → out_data=0x4020.
- Reset mid-pair: A accepted, then rst_n=0 asynchronously between clock edges → out_valid=0, pair_count=0, in_ready=1 immediately. After release, 0x09/0x03 → 0x0903.
- Counter wrap with CNT_W=2: deliver 5 pairs → pair_count sequence 1, 2, 3, 0, 1.
- With SUB_OPERAND_SWAP_EN and swap=1 at B: 0x05/0x12 → out_data=0x1205. With swap=0 → 0x0512.
